// File: rtl/ltc2308_scan_ctrl.sv
// ltc2308_scan_ctrl
// Scan sequencer for the LTC2308 8-channel 12-bit SPI ADC. Walks the enabled
// channels in ascending order, drives CONVST/SCK/SDI, deserialises SDO and
// keeps the latest result of each channel in an 8-entry bank. The ADC applies
// a config word to the conversion after the one it arrives with, so every
// scan opens with a prime frame whose returned data is thrown away.

module ltc2308_scan_ctrl #(
    parameter int CONV_CYCLES = 80,
    parameter int SCK_DIV     = 2,
    parameter int ACQ_CYCLES  = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic [7:0]  ch_mask,
    output logic        busy,
    output logic        scan_done,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_ACQ   = 2'd3
    } state_t;

    localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] DIV_LAST  = 16'(SCK_DIV - 1);
    localparam logic [15:0] ACQ_LAST  = 16'(ACQ_CYCLES - 1);

    // Config word, MSB first: SD=1 (single-ended), OS, S1, S0, UNI=1, SLP=0
    function automatic logic [5:0] cfg_word(input logic [2:0] ch);
        cfg_word = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    endfunction

    // Lowest enabled channel of a mask (0 when the mask is empty)
    function automatic logic [2:0] lowest_ch(input logic [7:0] mask);
        lowest_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            lowest_ch = mask[i] ? 3'(i) : lowest_ch;
        end
    endfunction

    // Next enabled channel strictly above cur: {found, channel}
    function automatic logic [3:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
        next_ch = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            next_ch = (mask[i] && (3'(i) > cur)) ? {1'b1, 3'(i)} : next_ch;
        end
    endfunction

    // SDI level for SHIFT bit k: config bits first, zeros for the remainder
    function automatic logic sdi_bit(input logic [5:0] cfg, input logic [3:0] k);
        logic [2:0] idx;
        idx     = 3'(4'd5 - k);
        sdi_bit = (k < 4'd6) ? cfg[idx] : 1'b0;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        hi_q, hi_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic        prime_q, prime_d;
    logic [5:0]  cfg_q, cfg_d;
    logic [11:0] sreg_q, sreg_d;
    logic        convst_q, convst_d;
    logic        sck_q, sck_d;
    logic        sdi_q, sdi_d;
    logic        busy_q, busy_d;
    logic        scan_done_q, scan_done_d;
    logic        sample_valid_q, sample_valid_d;
    logic [2:0]  sample_ch_q, sample_ch_d;
    logic [11:0] sample_data_q, sample_data_d;
    logic [11:0] rd_data_q, rd_data_d;
    logic [11:0] result_q [8];
    logic [11:0] result_d [8];
    logic        start_scan_s;
    logic [3:0]  nxt_s;
    logic [3:0]  nxt2_s;

    // Next-state, pin and result-bank logic for the scan sequencer
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        hi_d           = hi_q;
        mask_d         = mask_q;
        cur_ch_d       = cur_ch_q;
        prime_d        = prime_q;
        cfg_d          = cfg_q;
        sreg_d         = sreg_q;
        convst_d       = convst_q;
        sck_d          = sck_q;
        sdi_d          = sdi_q;
        busy_d         = busy_q;
        scan_done_d    = 1'b0;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        result_d       = result_q;
        rd_data_d      = result_q[rd_ch];
        start_scan_s   = 1'b0;
        nxt_s          = next_ch(mask_q, cur_ch_q);
        nxt2_s         = next_ch(mask_q, nxt_s[2:0]);

        case (state_q)
            ST_IDLE: begin
                if ((start || continuous) && (ch_mask != 8'd0)) begin
                    start_scan_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = 16'd0;
                    bit_d    = 4'd0;
                    hi_d     = 1'b0;
                    convst_d = 1'b0;
                    sck_d    = 1'b0;
                    sdi_d    = cfg_q[5];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (!hi_q) begin
                    // rising SCK: capture SDO, MSB first
                    hi_d   = 1'b1;
                    sck_d  = 1'b1;
                    sreg_d = {sreg_q[10:0], adc_sdo};
                    cnt_d  = 16'd0;
                end else if (bit_q == 4'd11) begin
                    state_d = ST_ACQ;
                    hi_d    = 1'b0;
                    sck_d   = 1'b0;
                    sdi_d   = 1'b0;
                    cnt_d   = 16'd0;
                end else begin
                    bit_d = bit_q + 4'd1;
                    hi_d  = 1'b0;
                    sck_d = 1'b0;
                    sdi_d = sdi_bit(cfg_q, bit_q + 4'd1);
                    cnt_d = 16'd0;
                end
            end
            ST_ACQ: begin
                if ((cnt_q == 16'd0) && !prime_q) begin
                    result_d[cur_ch_q] = sreg_q;
                    sample_valid_d     = 1'b1;
                    sample_ch_d        = cur_ch_q;
                    sample_data_d      = sreg_q;
                    scan_done_d        = !nxt_s[3];
                end else begin
                    sample_valid_d = 1'b0;
                end
                if (cnt_q != ACQ_LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (prime_q) begin
                    // prime done: first data frame returns cur_ch, requests the next one
                    prime_d  = 1'b0;
                    state_d  = ST_CONV;
                    cnt_d    = 16'd0;
                    convst_d = 1'b1;
                    cfg_d    = nxt_s[3] ? cfg_word(nxt_s[2:0]) : cfg_word(cur_ch_q);
                end else if (nxt_s[3]) begin
                    cur_ch_d = nxt_s[2:0];
                    state_d  = ST_CONV;
                    cnt_d    = 16'd0;
                    convst_d = 1'b1;
                    cfg_d    = nxt2_s[3] ? cfg_word(nxt2_s[2:0]) : cfg_word(nxt_s[2:0]);
                end else if (continuous && (ch_mask != 8'd0)) begin
                    start_scan_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                convst_d = 1'b0;
                sck_d    = 1'b0;
                sdi_d    = 1'b0;
            end
        endcase

        // New scan: latch the mask and open with a prime frame for the lowest channel
        if (start_scan_s) begin
            state_d  = ST_CONV;
            cnt_d    = 16'd0;
            mask_d   = ch_mask;
            cur_ch_d = lowest_ch(ch_mask);
            prime_d  = 1'b1;
            cfg_d    = cfg_word(lowest_ch(ch_mask));
            convst_d = 1'b1;
            busy_d   = 1'b1;
            sck_d    = 1'b0;
            sdi_d    = 1'b0;
        end else begin
            mask_d = mask_d;
        end
    end

    // State, pins, outputs and result bank; reset aborts any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 16'd0;
            bit_q          <= 4'd0;
            hi_q           <= 1'b0;
            mask_q         <= 8'd0;
            cur_ch_q       <= 3'd0;
            prime_q        <= 1'b0;
            cfg_q          <= 6'd0;
            sreg_q         <= 12'd0;
            convst_q       <= 1'b0;
            sck_q          <= 1'b0;
            sdi_q          <= 1'b0;
            busy_q         <= 1'b0;
            scan_done_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= 3'd0;
            sample_data_q  <= 12'd0;
            rd_data_q      <= 12'd0;
            for (int i = 0; i < 8; i++) begin
                result_q[i] <= 12'd0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            hi_q           <= hi_d;
            mask_q         <= mask_d;
            cur_ch_q       <= cur_ch_d;
            prime_q        <= prime_d;
            cfg_q          <= cfg_d;
            sreg_q         <= sreg_d;
            convst_q       <= convst_d;
            sck_q          <= sck_d;
            sdi_q          <= sdi_d;
            busy_q         <= busy_d;
            scan_done_q    <= scan_done_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            rd_data_q      <= rd_data_d;
            for (int i = 0; i < 8; i++) begin
                result_q[i] <= result_d[i];
            end
        end
    end

    assign busy         = busy_q;
    assign scan_done    = scan_done_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;
    assign rd_data      = rd_data_q;
    assign adc_convst   = convst_q;
    assign adc_sck      = sck_q;
    assign adc_sdi      = sdi_q;

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// Testbench for ltc2308_scan_ctrl: LTC2308 behavioural model on the pins,
// a frame-arithmetic reference model compared every cycle, and directed
// scenarios with hand-computed expectations.

module tb_ltc2308_scan_ctrl;

    localparam int CONV   = 80;
    localparam int DIV    = 2;
    localparam int ACQ    = 13;
    localparam int FRAME  = CONV + 24 * DIV + ACQ;   // 141
    localparam int SV_OFS = CONV + 24 * DIV + 1;     // 129

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  ch_mask = 8'd0;
    logic [2:0]  rd_ch = 3'd0;
    logic        adc_sdo = 1'b0;
    logic        busy, scan_done, sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data, rd_data;
    logic        adc_convst, adc_sck, adc_sdi;

    ltc2308_scan_ctrl #(.CONV_CYCLES(CONV), .SCK_DIV(DIV), .ACQ_CYCLES(ACQ)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .ch_mask(ch_mask), .busy(busy), .scan_done(scan_done),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .rd_ch(rd_ch), .rd_data(rd_data), .adc_convst(adc_convst),
        .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] cfg_of(input int ch);
        logic [2:0] c;
        c = ch[2:0];
        return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- LTC2308 pin model ----------------
    int         data_mode = 0;   // 0: returns 0xABC, 1: returns 0x100 + channel of applied config
    logic [5:0] cfg_rx = 6'd0;
    logic [5:0] cfg_applied = 6'd0;
    logic [11:0] adc_word = 12'd0;
    int         rx_bits = 0;
    int         sdo_idx = 0;
    int         convst_rises = 0;
    logic [5:0] sdi_log[$];

    initial forever begin
        @(posedge adc_convst);
        convst_rises++;
        cfg_applied = cfg_rx;
        rx_bits = 0;
    end

    initial forever begin
        @(negedge adc_convst);
        adc_word = (data_mode == 0) ? 12'hABC
                 : 12'h100 + {9'd0, cfg_applied[3], cfg_applied[2], cfg_applied[4]};
        sdo_idx = 11;
        adc_sdo = adc_word[11];
    end

    initial forever begin
        @(negedge adc_sck);
        if (sdo_idx > 0) begin
            sdo_idx--;
            adc_sdo = adc_word[sdo_idx];
        end
    end

    initial forever begin
        @(posedge adc_sck);
        if (rx_bits < 6) cfg_rx = {cfg_rx[4:0], adc_sdi};
        rx_bits++;
        if (rx_bits == 12) sdi_log.push_back(cfg_rx);
    end

    // ---------------- reference model ----------------
    int          m_active = 0;
    int          m_t = 0;
    int          m_n = 0;
    int          m_list[8];
    logic [11:0] m_result[8];
    logic        e_convst = 1'b0, e_sck = 1'b0, e_sdi = 1'b0, e_busy = 1'b0;
    logic        e_sv = 1'b0, e_done = 1'b0;
    logic [2:0]  e_ch = 3'd0;
    logic [11:0] e_data = 12'd0, e_rd = 12'd0;

    task automatic begin_scan(input logic [7:0] mask);
        m_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                m_list[m_n] = i;
                m_n++;
            end
        end
        m_t = 0;
        m_active = 1;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_active = 0;
            m_t = 0;
            for (int i = 0; i < 8; i++) m_result[i] = 12'd0;
            e_rd = 12'd0;
        end else begin
            e_rd = m_result[rd_ch];
            if (m_active != 0) begin
                m_t++;
                if (m_t == (m_n + 1) * FRAME) begin
                    if (continuous && ch_mask != 8'd0) begin_scan(ch_mask);
                    else m_active = 0;
                end
            end else if ((start || continuous) && ch_mask != 8'd0) begin
                begin_scan(ch_mask);
            end
        end
        e_convst = 1'b0; e_sck = 1'b0; e_sdi = 1'b0; e_busy = 1'b0;
        e_sv = 1'b0; e_done = 1'b0;
        if (m_active != 0) begin
            int f, p, s, k, tx;
            logic [5:0] cw;
            f = m_t / FRAME;
            p = m_t % FRAME;
            e_busy = 1'b1;
            e_convst = (p < CONV);
            if (p >= CONV && p < CONV + 24 * DIV) begin
                s = p - CONV;
                k = s / (2 * DIV);
                e_sck = ((s % (2 * DIV)) >= DIV);
                tx = m_list[(f < m_n) ? f : m_n - 1];
                cw = cfg_of(tx);
                e_sdi = (k < 6) ? cw[5 - k] : 1'b0;
            end
            if (f >= 1 && p == SV_OFS) begin
                e_sv = 1'b1;
                e_ch = m_list[f - 1][2:0];
                e_data = (data_mode == 0) ? 12'hABC : 12'h100 + {9'd0, e_ch};
                e_done = (f == m_n);
                m_result[e_ch] = e_data;
            end
        end
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("adc_convst", adc_convst, e_convst);
            check("adc_sck", adc_sck, e_sck);
            check("adc_sdi", adc_sdi, e_sdi);
            check("busy", busy, e_busy);
            check("sample_valid", sample_valid, e_sv);
            if (e_sv) begin
                check("sample_ch", sample_ch, e_ch);
                check("sample_data", sample_data, e_data);
            end
            check("scan_done", scan_done, e_done);
            check("rd_data", rd_data, e_rd);
        end
    end

    // ---------------- event monitors ----------------
    logic [2:0]  s_ch[$];
    logic [11:0] s_data[$];
    int          s_cyc[$];
    int          done_cyc[$];
    int          busy_rises = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
    logic        busy_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (sample_valid === 1'b1) begin
            s_ch.push_back(sample_ch);
            s_data.push_back(sample_data);
            s_cyc.push_back(cyc);
        end
        if (scan_done === 1'b1) done_cyc.push_back(cyc);
        if (busy === 1'b1 && !busy_prev) begin
            busy_rises++;
            busy_rise_cyc = cyc;
        end
        if (busy !== 1'b1 && busy_prev) busy_fall_cyc = cyc;
        busy_prev = (busy === 1'b1);
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input logic [7:0] mask);
        @(negedge clk);
        ch_mask = mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    logic [5:0]  exp_sdi[5];
    logic [2:0]  exp_ch[4];
    logic [11:0] exp_dat[4];

    initial begin
        int b_cv, b_s, b_d, b_br, b_l;
        exp_sdi = '{6'b100010, 6'b100110, 6'b111010, 6'b111110, 6'b111110};
        exp_ch  = '{3'd0, 3'd2, 3'd5, 3'd7};
        exp_dat = '{12'h100, 12'h102, 12'h105, 12'h107};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_convst", adc_convst, 1'b0);
        check("rst_sck", adc_sck, 1'b0);
        check("rst_sdi", adc_sdi, 1'b0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_rd_data", rd_data, 12'h000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single channel 0, ADC returns 0xABC
        data_mode = 0;
        b_cv = convst_rises; b_s = s_ch.size(); b_d = done_cyc.size(); b_l = sdi_log.size();
        pulse_start(8'h01);
        wait_idle("t1", 600);
        check("t1_frames", convst_rises - b_cv, 2);
        check("t1_sdi_count", sdi_log.size() - b_l, 2);
        for (int i = 0; i < 2; i++) check("t1_sdi", sdi_log[b_l + i], 6'b100010);
        check("t1_samples", s_ch.size() - b_s, 1);
        check("t1_ch", s_ch[b_s], 3'd0);
        check("t1_data", s_data[b_s], 12'hABC);
        check("t1_done_count", done_cyc.size() - b_d, 1);
        check("t1_done_with_valid", done_cyc[b_d], s_cyc[b_s]);
        check("t1_busy_len", busy_fall_cyc - busy_rise_cyc, 282);

        // mask 0xA5, echo data; start while busy must be ignored
        data_mode = 1;
        b_cv = convst_rises; b_s = s_ch.size(); b_l = sdi_log.size(); b_br = busy_rises;
        pulse_start(8'hA5);
        repeat (200) @(negedge clk);
        pulse_start(8'h3C);
        wait_idle("t2", 1000);
        check("t2_frames", convst_rises - b_cv, 5);
        check("t2_busy_rises", busy_rises - b_br, 1);
        check("t2_busy_len", busy_fall_cyc - busy_rise_cyc, 705);
        check("t2_samples", s_ch.size() - b_s, 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_ch", s_ch[b_s + i], exp_ch[i]);
            check("t2_data", s_data[b_s + i], exp_dat[i]);
        end
        check("t2_sdi_count", sdi_log.size() - b_l, 5);
        for (int i = 0; i < 5; i++) check("t2_sdi", sdi_log[b_l + i], exp_sdi[i]);
        rd_ch = 3'd7;
        @(negedge clk);
        check("t2_rd7", rd_data, 12'h107);
        rd_ch = 3'd2;
        @(negedge clk);
        check("t2_rd2", rd_data, 12'h102);
        rd_ch = 3'd1;
        @(negedge clk);
        check("t2_rd1", rd_data, 12'h000);

        // empty mask: start ignored
        b_cv = convst_rises; b_br = busy_rises;
        pulse_start(8'h00);
        repeat (500) @(negedge clk);
        check("t3_no_convst", convst_rises - b_cv, 0);
        check("t3_no_busy", busy_rises - b_br, 0);

        // continuous scanning of channels 0 and 7
        b_cv = convst_rises; b_d = done_cyc.size(); b_br = busy_rises; b_s = s_ch.size();
        @(negedge clk);
        ch_mask = 8'h81;
        continuous = 1'b1;
        begin
            int n = 0;
            while (done_cyc.size() < b_d + 3 && n < 1500) begin
                @(negedge clk);
                n++;
            end
        end
        continuous = 1'b0;
        check("t4_done_count", done_cyc.size() - b_d, 3);
        wait_idle("t4", 500);
        check("t4_gap1", done_cyc[b_d + 1] - done_cyc[b_d], 423);
        check("t4_gap2", done_cyc[b_d + 2] - done_cyc[b_d + 1], 423);
        check("t4_frames", convst_rises - b_cv, 9);
        check("t4_busy_rises", busy_rises - b_br, 1);
        check("t4_busy_len", busy_fall_cyc - busy_rise_cyc, 1269);
        check("t4_ch_a", s_ch[b_s], 3'd0);
        check("t4_data_a", s_data[b_s], 12'h100);
        check("t4_ch_b", s_ch[b_s + 1], 3'd7);
        check("t4_data_b", s_data[b_s + 1], 12'h107);

        // reset during SHIFT bit 5 (SCK high) of the third frame
        rd_ch = 3'd0;
        pulse_start(8'hA5);
        repeat (384) @(negedge clk);
        check("t5_pre_sck", adc_sck, 1'b1);
        check("t5_pre_rd0", rd_data, 12'h100);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_sck", adc_sck, 1'b0);
        check("t5_rst_convst", adc_convst, 1'b0);
        check("t5_rst_sdi", adc_sdi, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_rd", rd_data, 12'h000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            @(negedge clk);
            check("t5_bank_cleared", rd_data, 12'h000);
        end
        b_cv = convst_rises; b_s = s_ch.size();
        pulse_start(8'h01);
        wait_idle("t5", 600);
        check("t5_reprime_frames", convst_rises - b_cv, 2);
        check("t5_samples", s_ch.size() - b_s, 1);
        check("t5_data", s_data[b_s], 12'h100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ltc2308_scan_ctrl.md
# ltc2308_scan_ctrl

Sequencer for the on-board LTC2308 8-channel 12-bit SPI ADC. It scans a masked set of single-ended channels, drives CONVST/SCK/SDI, and deserialises SDO. Results land in an 8-entry result bank that the HPS reads through the lightweight bridge wrapper. The LTC2308 applies each config word to the following conversion, so the block inserts and discards a prime frame at the start of every scan.

## Interface
- CONV_CYCLES, 80: clk cycles CONVST is held high (covers tCONV = 1.6 µs at 50 MHz).
- SCK_DIV, 2: clk cycles per SCK half-period; minimum 1.
- ACQ_CYCLES, 13: idle clk cycles after readout, before the next CONVST.
- clk  in  1  system clock (FPGA_CLK1_50 domain).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan.
- continuous  in  1  when high, a new scan starts automatically after scan_done.
- ch_mask  in  8  enabled channels; latched at scan start.
- busy  out  1  high from scan start until the final frame's ACQ phase ends.
- scan_done  out  1  one-cycle pulse after the last enabled channel is stored.
- sample_valid  out  1  one-cycle pulse per stored result.
- sample_ch  out  3  channel of the current sample_valid.
- sample_data  out  12  data of the current sample_valid.
- rd_ch  in  3  result bank read address.
- rd_data  out  12  result[rd_ch], registered, valid 1 cycle after rd_ch.
- adc_convst, adc_sck, adc_sdi  out  1  ADC pins.
- adc_sdo  in  1  ADC serial data out.

## Operation
- States:
  - IDLE → CONV (CONVST high) → SHIFT (12 SCK periods) → ACQ → {CONV | IDLE}.
- Scan start is accepted only in IDLE, when start=1 or continuous=1, and the latched mask is nonzero.
  - ch_mask=0 ignores start; busy stays 0.
  - start while busy is ignored.
- On acceptance:
  - Latch ch_mask into mask_q.
  - Set cur_ch = lowest set bit.
  - Set the prime flag.
- Config word for channel c, MSB first: {SD=1, OS=c[0], S1=c[2], S0=c[1], UNI=1, SLP=0}.
- Prime frame: sends cfg(first channel); its SDO data is discarded.
- Data frames:
  - Each frame sends cfg(next enabled channel after cur_ch). If cur_ch is the last enabled channel, it sends cfg(cur_ch).
  - Each frame returns data for cur_ch.
- Frames per scan = popcount(mask_q) + 1.
- cur_ch advances ascending through mask_q; no wrap within a scan.
- Store, in the first ACQ cycle of a data frame:
  - result[cur_ch] ← shift register.
  - sample_valid=1, with sample_ch and sample_data matching.
- scan_done pulses in the same cycle as the last store.
- continuous:
  - Sampled in the last ACQ cycle. If it is 1, the next scan starts in the following cycle (new mask latch and a new prime frame).
  - If it is 1 but ch_mask=0, go to IDLE.
- Reset behaviour:
  - All outputs 0; adc_convst, adc_sck, adc_sdi low.
  - result[0..7] = 0; state IDLE.
  - Reset mid-frame aborts the frame. The next scan re-primes.

## Timing
- start sampled at edge 0 → adc_convst and busy high from edge 1, for CONV_CYCLES cycles.
- SHIFT bit k (k = 0..11):
  - SCK low for SCK_DIV cycles. adc_sdi = cfg[5-k] for k<6, else 0, set at the start of the low phase.
  - Then SCK high for SCK_DIV cycles. adc_sdo is sampled on the clk edge that drives SCK high and shifted in MSB first.
- SCK idles low; exactly 12 rising edges per frame.
- Frame length = CONV_CYCLES + 24·SCK_DIV + ACQ_CYCLES (defaults: 141 cycles, 2.82 µs).
- sample_valid occurs CONV_CYCLES + 24·SCK_DIV + 1 cycles after that frame's CONVST rises.
- busy falls after the final ACQ phase, unless continuous restarts the scan.
- rd_data is updated every cycle from result[rd_ch]. A store and a read of the same channel in the same cycle returns the old value; the new value appears the next cycle.

## Test plan
- ch_mask=0x01, start pulse, ADC model returns 0xABC:
  - 2 frames; SDI of both frames = 100010.
  - sample_valid once with ch=0, data=0xABC.
  - scan_done coincident with sample_valid.
  - busy falls 282 cycles after start.
- ch_mask=0xA5, model returns 0x100+ch of the config it received one frame earlier:
  - Results ch 0, 2, 5, 7 = 0x100, 0x102, 0x105, 0x107, in that order.
  - SDI sequence: cfg0, cfg2, cfg5, cfg7, cfg7.
- ch_mask=0x00 with start → no CONVST edge, busy stays 0 for 500 cycles.
- continuous=1, ch_mask=0x81:
  - Back-to-back scans, each of 3 frames, with no idle cycle between scans.
  - scan_done every 423 cycles.
  - Drop continuous → busy falls after the current scan.
- reset asserted during SHIFT bit 5 of frame 2:
  - Pins go low immediately; result bank reads 0.
  - The next start re-primes (extra discarded frame).
- start while busy → ignored; frame count and timing unchanged. rd_ch=7 after the 0xA5 scan → rd_data=0x107 on the next cycle.
